// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI serial-clock generator.
package spi_pkg;

  localparam int unsigned DIV_W = 3;
  localparam int unsigned CNT_W = (1 << DIV_W) - 1;

  // Terminal count for a half-period of 2^divider clk cycles.
  function automatic logic [CNT_W-1:0] half_minus1(input logic [DIV_W-1:0] divider);
    logic [CNT_W:0] half;
    half = (CNT_W+1)'(1) << divider;
    return CNT_W'(half - (CNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Configuration, chip-select and generated-clock signals of spi_sclk_gen.
interface spi_sclk_gen_if;
  import spi_pkg::*;

  logic [DIV_W-1:0] divider;
  logic             cpol;
  logic             cs;
  logic             sclk;
  logic             sclk_pe;
  logic             sclk_ne;

  modport master (output divider, output cpol, output cs,
                  input  sclk,    input  sclk_pe, input sclk_ne);
  modport slave  (input  divider, input  cpol,   input  cs,
                  output sclk,    output sclk_pe, output sclk_ne);
endinterface

// File: rtl/sclk_edge_detect.sv
// Delayed SCLK copy plus rise/fall strobes, gated off while chip-select is inactive.
module sclk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_gate_i,
  output logic pe_o,
  output logic ne_o
);

  logic sclk_dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sclk_dly_q <= 1'b0;
    else      sclk_dly_q <= sclk_i;
  end

  assign pe_o =  sclk_i & ~sclk_dly_q & ~cs_gate_i;
  assign ne_o = ~sclk_i &  sclk_dly_q & ~cs_gate_i;

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: power-of-two divider, CPOL idle level, edge strobes.
// Build option SPI_SCLK_CFG_LATCH_EN freezes divider/cpol for the duration of a transfer.
module spi_sclk_gen
  import spi_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  spi_sclk_gen_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic [DIV_W-1:0] div_eff;
  logic             cpol_eff;

`ifdef SPI_SCLK_CFG_LATCH_EN
  logic [DIV_W-1:0] div_sh_q;
  logic             cpol_sh_q;

  // Shadows track the live config while idle and hold it during a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_sh_q  <= '0;
      cpol_sh_q <= 1'b0;
    end else if (bus.cs) begin
      div_sh_q  <= bus.divider;
      cpol_sh_q <= bus.cpol;
    end
  end

  assign div_eff  = bus.cs ? bus.divider : div_sh_q;
  assign cpol_eff = bus.cs ? bus.cpol    : cpol_sh_q;
`else
  assign div_eff  = bus.divider;
  assign cpol_eff = bus.cpol;
`endif

  // Counter clears at or above terminal so a divider shrink never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (bus.cs) begin
      cnt_d  = '0;
      sclk_d = cpol_eff;
    end else if (cnt_q >= half_minus1(div_eff)) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign bus.sclk = sclk_q;

  sclk_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .sclk_i    (sclk_q),
    .cs_gate_i (bus.cs),
    .pe_o      (bus.sclk_pe),
    .ne_o      (bus.sclk_ne)
  );

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: per-cycle model predictions plus directed timing checks.
module tb_spi_sclk_gen;
  import spi_pkg::*;

  typedef struct packed {
    logic sclk;
    logic pe;
    logic ne;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_sclk_gen_if bus ();

  spi_sclk_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pe_cnt = 0;
  int   ne_cnt = 0;
  obs_t exp_q[$];

  // Reference model state
  int         m_cnt = 0;
  logic       m_sclk = 1'b0;
  logic       m_dly = 1'b0;
  logic [2:0] m_div_sh = 3'd0;
  logic       m_cpol_sh = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sclk = 1'b0; m_dly = 1'b0; m_div_sh = 3'd0; m_cpol_sh = 1'b0;
    exp_q.delete();
  endtask

  // Predict one clk edge, push the expectation, then compare after the edge.
  task automatic step();
    obs_t       e;
    obs_t       got;
    logic [2:0] dv;
    logic       cp;
    int         hm;
`ifdef SPI_SCLK_CFG_LATCH_EN
    dv = bus.cs ? bus.divider : m_div_sh;
    cp = bus.cs ? bus.cpol    : m_cpol_sh;
    if (bus.cs) begin
      m_div_sh  = bus.divider;
      m_cpol_sh = bus.cpol;
    end
`else
    dv = bus.divider;
    cp = bus.cpol;
`endif
    hm    = (1 << dv) - 1;
    m_dly = m_sclk;
    if (bus.cs) begin
      m_cnt  = 0;
      m_sclk = cp;
    end else if (m_cnt >= hm) begin
      m_cnt  = 0;
      m_sclk = ~m_sclk;
    end else begin
      m_cnt++;
    end
    e.sclk = m_sclk;
    e.pe   = m_sclk & ~m_dly & ~bus.cs;
    e.ne   = ~m_sclk & m_dly & ~bus.cs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.sclk, bus.sclk_pe, bus.sclk_ne};
    e   = exp_q.pop_front();
    check("cycle", 32'(got), 32'(e));
    if (bus.sclk_pe) pe_cnt++;
    if (bus.sclk_ne) ne_cnt++;
  endtask

  // Step until sclk changes; n is the number of edges taken (bounded).
  task automatic wait_toggle(output int n);
    logic start;
    start = bus.sclk;
    n = 0;
    while (bus.sclk === start && n < 300) begin
      step();
      n++;
    end
  endtask

  int n;
  int first;
  int exp_shrink;
  int exp_after;
  logic prev;

  initial begin
    bus.cs      = 1'b0;
    bus.divider = 3'd2;
    bus.cpol    = 1'b1;
    rst         = 1'b0;

    // Reset holds everything low even with cs active and cpol=1
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'({bus.sclk, bus.sclk_pe, bus.sclk_ne}), 32'd0);
    end
    bus.cs = 1'b1;
    rst    = 1'b1;
    model_reset();
    step();
    check("rel_sclk", 32'(bus.sclk), 32'd1);

    // divider=0, cpol=0: period 2, pe after E0/E2/E4
    bus.cpol = 1'b0;
    step();
    bus.divider = 3'd0;
    bus.cs = 1'b0;
    pe_cnt = 0; ne_cnt = 0;
    step();
    check("d0_e0_pe", 32'(bus.sclk_pe), 32'd1);
    repeat (5) step();
    check("d0_pe_cnt", 32'(pe_cnt), 32'd3);
    check("d0_ne_cnt", 32'(ne_cnt), 32'd3);

    // Asynchronous reset mid-transfer drops everything at once
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst", 32'({bus.sclk, bus.sclk_pe, bus.sclk_ne}), 32'd0);
    bus.cs = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // divider=2, cpol=1, 40 cycles low: first toggle on edge 4, 5 pe and 5 ne
    bus.divider = 3'd2;
    bus.cpol = 1'b1;
    repeat (2) step();
    bus.cs = 1'b0;
    pe_cnt = 0; ne_cnt = 0; first = 0;
    prev = bus.sclk;
    for (int i = 0; i < 40; i++) begin
      step();
      if (first == 0 && bus.sclk !== prev) first = i + 1;
    end
    check("d2_first", 32'(first), 32'd4);
    check("d2_pe_cnt", 32'(pe_cnt), 32'd5);
    check("d2_ne_cnt", 32'(ne_cnt), 32'd5);
    bus.cs = 1'b1;
    repeat (4) step();
    check("d2_idle_pe", 32'(pe_cnt), 32'd5);
    check("d2_idle_ne", 32'(ne_cnt), 32'd5);

    // cs pulled high while sclk is non-idle, then re-asserted
    bus.divider = 3'd1;
    bus.cpol = 1'b0;
    step();
    bus.cs = 1'b0;
    wait_toggle(n);
    check("mid_first", 32'(n), 32'd2);
    bus.cs = 1'b1;
    pe_cnt = 0; ne_cnt = 0;
    step();
    check("mid_idle", 32'(bus.sclk), 32'd0);
    check("mid_no_ne", 32'(ne_cnt), 32'd0);
    bus.cs = 1'b0;
    wait_toggle(n);
    check("mid_restart", 32'(n), 32'd2);

    // cpol flips while idle: sclk follows, no strobes
    bus.cs = 1'b1;
    step();
    pe_cnt = 0; ne_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.cpol = ~bus.cpol;
      step();
      check("cpol_follow", 32'(bus.sclk), 32'(bus.cpol));
    end
    check("cpol_no_pe", 32'(pe_cnt), 32'd0);
    check("cpol_no_ne", 32'(ne_cnt), 32'd0);

    // divider=7: 128-cycle half-periods, then shrink to 0 with counter at 50
    bus.cpol = 1'b0;
    bus.divider = 3'd7;
    repeat (2) step();
    bus.cs = 1'b0;
    wait_toggle(n);
    check("d7_first", 32'(n), 32'd128);
    wait_toggle(n);
    check("d7_half", 32'(n), 32'd128);
    repeat (50) step();
    bus.divider = 3'd0;
`ifdef SPI_SCLK_CFG_LATCH_EN
    exp_shrink = 78;
    exp_after  = 128;
`else
    exp_shrink = 1;
    exp_after  = 1;
`endif
    wait_toggle(n);
    check("shrink", 32'(n), 32'(exp_shrink));
    wait_toggle(n);
    check("after_shrink", 32'(n), 32'(exp_after));
    bus.cs = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
